// File: rtl/alu_seq.sv
// Sequenced EX-stage ALU: single-cycle ops return in one cycle, MULT/DIV iterate one bit per
// cycle into HI/LO. The controller stalls on in_ready / out_valid.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       aluc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             busy
);

  localparam logic [4:0] OP_ADD  = 5'h02, OP_SUBU = 5'h01, OP_SUB  = 5'h03;
  localparam logic [4:0] OP_AND  = 5'h04, OP_OR   = 5'h05, OP_XOR  = 5'h06, OP_NOR = 5'h07;
  localparam logic [4:0] OP_LUI0 = 5'h08, OP_LUI1 = 5'h09, OP_SLTU = 5'h0A, OP_SLT = 5'h0B;
  localparam logic [4:0] OP_SRA  = 5'h0C, OP_SRL  = 5'h0D, OP_SLL  = 5'h0E;
  localparam logic [4:0] OP_MULT = 5'h10, OP_MULTU = 5'h11, OP_DIV = 5'h12, OP_DIVU = 5'h13;
  localparam logic [4:0] OP_MFHI = 5'h14, OP_MFLO = 5'h15;
  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [SHW-1:0]   cnt;
  logic             sgn, neg_q, neg_r, div_ovf;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid and r/flags hold until out_ready, and in_ready is low until that result is taken.
  logic accept, is_mul_op, is_div_op, op_sgn;
  assign accept    = in_valid & in_ready;
  assign is_mul_op = (aluc == OP_MULT) | (aluc == OP_MULTU);
  assign is_div_op = (aluc == OP_DIV)  | (aluc == OP_DIVU);
  assign op_sgn    = (aluc == OP_MULT) | (aluc == OP_DIV);

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   shamt, sh_m1, lsh_idx;
  logic             rsh_c, lsh_c;
  logic [WIDTH-1:0] sc_r;
  logic             sc_c, sc_v;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign shamt   = a[SHW-1:0];
  assign sh_m1   = shamt - SHW'(1);
  assign lsh_idx = SHW'(WIDTH) - shamt;
  assign rsh_c   = (shamt != '0) & b[sh_m1];
  assign lsh_c   = (shamt != '0) & b[lsh_idx];

  always_comb begin
    sc_r = sum[WIDTH-1:0];
    sc_c = sum[WIDTH];
    sc_v = (aluc == OP_ADD) & (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
    case (aluc)
      OP_SUBU, OP_SUB: begin
        sc_r = diff[WIDTH-1:0];
        sc_c = diff[WIDTH];
        sc_v = (aluc == OP_SUB) & (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  begin sc_r = a & b;    sc_c = 1'b0; sc_v = 1'b0; end
      OP_OR:   begin sc_r = a | b;    sc_c = 1'b0; sc_v = 1'b0; end
      OP_XOR:  begin sc_r = a ^ b;    sc_c = 1'b0; sc_v = 1'b0; end
      OP_NOR:  begin sc_r = ~(a | b); sc_c = 1'b0; sc_v = 1'b0; end
      OP_LUI0, OP_LUI1: begin
        sc_r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
        sc_c = 1'b0; sc_v = 1'b0;
      end
      OP_SLTU: begin sc_r = {{(WIDTH-1){1'b0}}, diff[WIDTH]}; sc_c = 1'b0; sc_v = 1'b0; end
      OP_SLT: begin
        sc_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
        sc_c = 1'b0; sc_v = 1'b0;
      end
      OP_SRA:  begin sc_r = $signed(b) >>> shamt; sc_c = rsh_c; sc_v = 1'b0; end
      OP_SRL:  begin sc_r = b >> shamt;           sc_c = rsh_c; sc_v = 1'b0; end
      OP_SLL:  begin sc_r = b << shamt;           sc_c = lsh_c; sc_v = 1'b0; end
      OP_MFHI: begin sc_r = hi; sc_c = 1'b0; sc_v = 1'b0; end
      OP_MFLO: begin sc_r = lo; sc_c = 1'b0; sc_v = 1'b0; end
      default: ;
    endcase
  end

  // ---------------- iterative datapath ----------------
  logic [WIDTH-1:0]   mul_add, step_hi, step_lo, fin_hi, fin_lo, quo, rem;
  logic [WIDTH:0]     mul_sum, div_tr, div_df;
  logic [2*WIDTH-1:0] prod, prod_n;
  logic               fin_v;
  logic [WIDTH-1:0]   mag_a, mag_b;

  assign mag_a   = (op_sgn & a[WIDTH-1]) ? -a : a;
  assign mag_b   = (op_sgn & b[WIDTH-1]) ? -b : b;
  assign mul_add = acc_lo[0] ? opnd : '0;
  assign mul_sum = {1'b0, acc_hi} + {1'b0, mul_add};
  assign div_tr  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_df  = div_tr - {1'b0, opnd};

  always_comb begin
    if (state == S_MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (!div_df[WIDTH]) begin
      step_hi = div_df[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      step_hi = div_tr[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

  // Final result is formed from the last step directly, so out_valid rises WIDTH cycles after load.
  always_comb begin
    prod   = {step_hi, step_lo};
    prod_n = neg_q ? -prod : prod;
    quo    = neg_q ? -step_lo : step_lo;
    rem    = neg_r ? -step_hi : step_hi;
    if (state == S_MUL) begin
      fin_hi = prod_n[2*WIDTH-1:WIDTH];
      fin_lo = prod_n[WIDTH-1:0];
      fin_v  = sgn ? (fin_hi != {WIDTH{fin_lo[WIDTH-1]}}) : (fin_hi != '0);
    end else begin
      fin_hi = rem;
      fin_lo = (opnd == '0) ? '1 : quo;
      fin_v  = (opnd == '0) | div_ovf;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = is_mul_op ? S_MUL : (is_div_op ? S_DIV : S_DONE);
      S_MUL, S_DIV: if (cnt == CNT_LAST) state_nx = S_DONE;
      S_DONE: if (out_valid && out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = rst_n & (state == S_IDLE) & ~out_valid;
    busy     = (state == S_MUL) | (state == S_DIV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi <= '0; acc_lo <= '0; opnd <= '0; cnt <= '0;
      sgn <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0; div_ovf <= 1'b0;
      r <= '0; hi <= '0; lo <= '0; out_valid <= 1'b0;
      zero <= 1'b0; carry <= 1'b0; negative <= 1'b0; overflow <= 1'b0;
    end else if (state == S_IDLE && accept) begin
      if (is_mul_op || is_div_op) begin
        acc_hi  <= '0;
        acc_lo  <= mag_a;
        opnd    <= mag_b;
        cnt     <= '0;
        sgn     <= op_sgn;
        neg_q   <= op_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r   <= op_sgn & a[WIDTH-1];
        div_ovf <= (aluc == OP_DIV) & (a == MIN_VAL) & (&b);
      end else begin
        r         <= sc_r;
        zero      <= (sc_r == '0);
        negative  <= sc_r[WIDTH-1];
        carry     <= sc_c;
        overflow  <= sc_v;
        out_valid <= 1'b1;
      end
    end else if (state == S_MUL || state == S_DIV) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= cnt + SHW'(1);
      if (cnt == CNT_LAST) begin
        hi        <= fin_hi;
        lo        <= fin_lo;
        r         <= fin_lo;
        zero      <= (fin_lo == '0);
        negative  <= fin_lo[WIDTH-1];
        carry     <= 1'b0;
        overflow  <= fin_v;
        out_valid <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq (WIDTH=32) against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [4:0]   aluc = '0;
  logic         in_ready, out_valid, zero, carry, negative, overflow, busy;
  logic [W-1:0] r, hi, lo;

  int n_checks = 0, n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_hi = '0, m_lo = '0;

  alu_seq #(.WIDTH(W), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .aluc(aluc), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .hi(hi), .lo(lo), .zero(zero), .carry(carry), .negative(negative),
    .overflow(overflow), .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: results from plain integer arithmetic; HI/LO tracked in m_hi/m_lo.
  task automatic model(input logic [4:0] op, input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] er, output logic ec, output logic eo);
    longint sa, sb, t;
    logic [63:0] w, pv;
    logic [4:0] sh;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    sh = ma[4:0];
    ec = 1'b0; eo = 1'b0;
    case (op)
      5'h01, 5'h03: begin
        er = ma - mb; ec = (ma < mb);
        t = sa - sb; eo = (op == 5'h03) && (t > SMAX || t < SMIN);
      end
      5'h04: er = ma & mb;
      5'h05: er = ma | mb;
      5'h06: er = ma ^ mb;
      5'h07: er = ~(ma | mb);
      5'h08, 5'h09: er = {mb[15:0], 16'h0000};
      5'h0A: er = (ma < mb) ? 1 : 0;
      5'h0B: er = (sa < sb) ? 1 : 0;
      5'h0C: begin er = $signed(mb) >>> sh; w = {mb, 32'h0} >> sh; ec = w[31]; end
      5'h0D: begin er = mb >> sh;           w = {mb, 32'h0} >> sh; ec = w[31]; end
      5'h0E: begin w = {32'h0, mb} << sh; er = w[31:0]; ec = w[32]; end
      5'h10: begin
        t = sa * sb; pv = t;
        m_hi = pv[63:32]; m_lo = pv[31:0]; er = m_lo;
        eo = (t > SMAX || t < SMIN);
      end
      5'h11: begin
        pv = {32'h0, ma} * {32'h0, mb};
        m_hi = pv[63:32]; m_lo = pv[31:0]; er = m_lo;
        eo = (m_hi != 0);
      end
      5'h12: begin
        if (mb == 0) begin m_lo = '1; m_hi = ma; eo = 1'b1; end
        else begin
          t = sa / sb; pv = t; m_lo = pv[31:0];
          t = sa % sb; pv = t; m_hi = pv[31:0];
          eo = (ma == 32'h8000_0000) && (mb == 32'hFFFF_FFFF);
        end
        er = m_lo;
      end
      5'h13: begin
        if (mb == 0) begin m_lo = '1; m_hi = ma; eo = 1'b1; end
        else begin m_lo = ma / mb; m_hi = ma % mb; end
        er = m_lo;
      end
      5'h14: er = m_hi;
      5'h15: er = m_lo;
      default: begin
        w = {32'h0, ma} + {32'h0, mb}; er = w[31:0]; ec = w[32];
        t = sa + sb; eo = (op == 5'h02) && (t > SMAX || t < SMIN);
      end
    endcase
  endtask

  // Driver: issue one op, wait for its result, optionally stall the consumer, then check.
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] opa, input logic [W-1:0] opb,
                        input int stall);
    logic [W-1:0] er, eq;
    logic ec, eo;
    int lat, guard;
    bit iter;
    iter = (op >= 5'h10) && (op <= 5'h13);
    guard = 0;
    while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
    check_eq("in_ready_idle", in_ready, 1);
    aluc = op; a = opa; b = opb; in_valid = 1'b1;
    model(op, opa, opb, er, ec, eo);
    exp_q.push_back(er);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; aluc = 5'($urandom_range(0, 31));
    if (iter) check_eq("busy", busy, 1);
    lat = 1;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    check_eq("latency", lat, iter ? W + 1 : 1);
    eq = exp_q.pop_front();
    if (!out_valid) return;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("hold", {out_valid, in_ready, r}, {1'b1, 1'b0, eq});
    end
    check_eq("r", r, eq);
    check_eq("zero", zero, eq == 0);
    check_eq("negative", negative, eq[W-1]);
    check_eq("carry", carry, ec);
    check_eq("overflow", overflow, eo);
    check_eq("hi", hi, m_hi);
    check_eq("lo", lo, m_lo);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("release", {out_valid, in_ready, busy}, 3'b010);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [4:0] op;
    #1;
    check_eq("reset_outs", {in_ready, out_valid, busy, zero, carry, negative, overflow}, 7'b0);
    check_eq("reset_regs", {r, hi}, 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(5'h02, 32'h7FFF_FFFF, 32'h1, 0);
    run_op(5'h01, 32'h3, 32'h5, 0);
    run_op(5'h0D, 32'h1, 32'h3, 0);
    run_op(5'h10, 32'hFFFF_FFFE, 32'h3, 0);
    run_op(5'h14, 32'h0, 32'h0, 0);
    run_op(5'h15, 32'h0, 32'h0, 0);
    run_op(5'h12, 32'hFFFF_FFF9, 32'h2, 1);
    run_op(5'h13, 32'h0000_1234, 32'h0, 0);
    run_op(5'h12, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(5'h12, 32'hFFFF_FF00, 32'h0, 0);
    run_op(5'h00, 32'h1111_1111, 32'h2222_2222, 5);
    run_op(5'h0E, 32'h0, 32'h8000_0001, 0);
    run_op(5'h0E, 32'h21, 32'h8000_0001, 0);
    run_op(5'h0C, 32'h4, 32'h8000_0018, 0);
    run_op(5'h1F, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run_op(5'h08, 32'h0, 32'hABCD_1234, 0);
    run_op(5'h0B, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(5'h0A, 32'hFFFF_FFFF, 32'h1, 0);

    // Reset in the middle of a divide: outputs clear at once, nothing comes out afterwards.
    run_op(5'h11, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    aluc = 5'h12; a = 32'h0000_0064; b = 32'h7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("busy_mid_div", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_outs", {in_ready, out_valid, busy, zero, carry, negative, overflow}, 7'b0);
    check_eq("abort_r", r, 0);
    check_eq("abort_hilo", {hi, lo}, 64'h0);
    m_hi = '0; m_lo = '0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_ready", {in_ready, out_valid}, 2'b10);
    repeat (40) @(negedge clk);
    check_eq("no_stale_valid", {out_valid, busy}, 2'b00);
    run_op(5'h14, 32'h0, 32'h0, 0);

    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(16, 21)) : 5'($urandom_range(0, 31));
      run_op(op, pick(), pick(), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
